imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the CPU's instruction memory. Accepts a byte stream over a valid/ready handshake, parses a 2-byte word-count header, packs payload bytes big-endian into 32-bit instructions, and writes them sequentially into instruction memory starting at word address 0. Holds the CPU in reset until the load completes, then releases it.

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM states, word packing constants.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_PAYLOAD,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic rx_state(state_t s);
        return s inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CHECK};
    endfunction

    function automatic logic busy_state(state_t s);
        return s inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_WRITE, S_CHECK};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream valid/ready channel feeding the instruction memory loader.
// master = byte source, slave = loader.
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_ready pulses
// combinationally alongside the fourth byte of each word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clr) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (push) begin
            lane_d  = lane_q + 1'b1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_ready_o = push && !clr &&
                          (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 2-byte word count header, big-endian payload into imem.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  rx,
    output logic          imem_write_enabled,
    output logic [31:0]   imem_address,
    output logic [31:0]   imem_data,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic          err_checksum
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH:0]   index_q, index_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  rdy_q, rdy_d;
    logic                  we_q, we_d;
    logic                  cpurst_q, cpurst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  xfer;
    logic                  start_ok;
    logic                  pk_push;
    logic                  pk_ready;
    logic [31:0]           pk_word;
    logic [15:0]           hdr_count;
    logic [ADDR_WIDTH:0]   index_next;

    assign xfer       = rx.rx_valid && rdy_q;
    assign start_ok   = start &&
                        (state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign pk_push    = xfer && (state_q == S_PAYLOAD);
    assign hdr_count  = {count_q[15:8], rx.rx_data};
    assign index_next = index_q + 1'b1;

    imem_loader_byte_packer u_packer (
        .clk          (clock),
        .rst          (reset),
        .clr          (start_ok),
        .push         (pk_push),
        .byte_i       (rx.rx_data),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       cerr_q, cerr_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        cerr_d  = cerr_q;
        if (start_ok) begin
            csum_d = '0;
            cerr_d = 1'b0;
        end else if (pk_push) begin
            csum_d = csum_q ^ rx.rx_data;
        end
`endif
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    state_d = S_HDR_HI;
                    count_d = '0;
                    index_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = rx.rx_data;
                    state_d       = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_count;
                    if ({1'b0, hdr_count} > MAX_WORDS) begin
                        state_d = S_ERROR;
                        ovf_d   = 1'b1;
                    end else if (hdr_count == 16'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pk_ready) begin
                    state_d = S_WRITE;
                    data_d  = pk_word;
                    addr_d  = index_q[ADDR_WIDTH-1:0];
                end
            end
            S_WRITE: begin
                index_d = index_next;
                state_d = (16'(index_next) == count_q) ? S_FINISH
                                                       : S_PAYLOAD;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    if (rx.rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERROR;
                        cerr_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // outputs are registered from the next state
        rdy_d    = rx_state(state_d);
        we_d     = (state_d == S_WRITE);
        busy_d   = busy_state(state_d);
        done_d   = (state_d == S_DONE);
        cpurst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            index_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            cpurst_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            index_q  <= index_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            we_q     <= we_d;
            cpurst_q <= cpurst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            csum_q <= '0;
            cerr_q <= 1'b0;
        end else begin
            csum_q <= csum_d;
            cerr_q <= cerr_d;
        end
    end
    assign err_checksum = cerr_q;
`else
    assign err_checksum = 1'b0;
`endif

    assign rx.rx_ready          = rdy_q;
    assign imem_write_enabled   = we_q;
    assign imem_address         = {{(32-ADDR_WIDTH){1'b0}}, addr_q};
    assign imem_data            = data_q;
    assign cpu_reset            = cpurst_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err_overflow         = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (both checksum builds).
// Inputs change on negedge, outputs sampled at negedge or #1 after posedge.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic        imem_write_enabled;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        cpu_reset, busy, done, err_overflow, err_checksum;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(10)) dut (
        .clock              (clk),
        .reset              (rst),
        .start              (start),
        .rx                 (bus),
        .imem_write_enabled (imem_write_enabled),
        .imem_address       (imem_address),
        .imem_data          (imem_data),
        .cpu_reset          (cpu_reset),
        .busy               (busy),
        .done               (done),
        .err_overflow       (err_overflow),
        .err_checksum       (err_checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nw = 0;
    logic [31:0] wr_addr [2048];
    logic [31:0] wr_data [2048];
    int          wr_cyc  [2048];

    always @(posedge clk) begin
        #1;
        if (imem_write_enabled) begin
            if (nw < 2048) begin
                wr_addr[nw] <= imem_address;
                wr_data[nw] <= imem_data;
                wr_cyc[nw]  <= cyc;
            end
            nw <= nw + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap,
                             output int t);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!bus.rx_ready) begin
            check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
            bus.rx_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_load(input logic [7:0] s[$], input int gap,
                             output int t0);
        int t;
        t0 = 0;
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gap, t);
            if (i == 0) t0 = t;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output int t);
        int n = 0;
        while (!done && !err_overflow && !err_checksum && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (n >= 50) check("end_wait", 32'(done), 32'd1);
    endtask

    logic [7:0] s1[$];
    logic [7:0] sq[$];
    int t0, td, base;

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        s1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h8C, 8'h09, 8'h00, 8'h04};
        if (CS == 1) s1.push_back(8'hAC);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_we", 32'(imem_write_enabled), 32'd0);
        check("rst_addr", imem_address, 32'd0);
        check("rst_data", imem_data, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_flags", {busy, done, err_overflow, err_checksum}, 32'd0);

        // valid outside ready states must be ignored
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("idle_ignore", {bus.rx_ready, busy}, 32'd0);
        bus.rx_valid = 1'b0;

        // back-to-back load
        base = nw;
        do_start();
        check("start_busy", {busy, cpu_reset, done}, 32'b110);
        send_load(s1, 0, t0);
        wait_end(td);
        check("t1_nw", nw - base, 32'd2);
        check("t1_a0", wr_addr[base], 32'd0);
        check("t1_d0", wr_data[base], 32'h20080005);
        check("t1_a1", wr_addr[base+1], 32'd1);
        check("t1_d1", wr_data[base+1], 32'h8C090004);
        check("t1_w0_lat", wr_cyc[base] - t0, 32'd6);
        check("t1_w1_lat", wr_cyc[base+1] - t0, 32'd11);
        check("t1_done_lat", td - t0, 32'(12 + CS));
        check("t1_end", {done, cpu_reset, busy}, 32'b100);

        // same stream with gaps in rx_valid
        base = nw;
        do_start();
        check("restart", {done, cpu_reset, busy}, 32'b011);
        send_load(s1, 1, t0);
        wait_end(td);
        check("t2_nw", nw - base, 32'd2);
        check("t2_d0", wr_data[base], 32'h20080005);
        check("t2_d1", wr_data[base+1], 32'h8C090004);
        check("t2_a1", wr_addr[base+1], 32'd1);
        check("t2_done", {done, cpu_reset}, 32'b10);

        // count above memory depth
        base = nw;
        do_start();
        sq = '{8'h04, 8'h01};
        send_load(sq, 0, t0);
        repeat (3) @(negedge clk);
        check("ovf_flag", 32'(err_overflow), 32'd1);
        check("ovf_state", {cpu_reset, busy, done, bus.rx_ready}, 32'b1000);
        check("ovf_nw", nw - base, 32'd0);

        // count exactly at memory depth
        base = nw;
        do_start();
        check("ovf_clear", 32'(err_overflow), 32'd0);
        sq = '{8'h04, 8'h00};
        for (int i = 0; i < 1024; i++) begin
            sq.push_back(8'h00);
            sq.push_back(8'h00);
            sq.push_back(8'(i >> 8));
            sq.push_back(8'(i));
        end
        if (CS == 1) sq.push_back(8'h00);
        send_load(sq, 0, t0);
        wait_end(td);
        check("full_nw", nw - base, 32'd1024);
        check("full_d5", wr_data[base+5], 32'h5);
        check("full_alast", wr_addr[base+1023], 32'h3FF);
        check("full_dlast", wr_data[base+1023], 32'h3FF);
        check("full_done", {done, err_overflow}, 32'b10);

        // zero count
        base = nw;
        do_start();
        sq = '{8'h00, 8'h00};
        if (CS == 1) sq.push_back(8'h00);
        send_load(sq, 0, t0);
        wait_end(td);
        check("zero_nw", nw - base, 32'd0);
        check("zero_done", {done, cpu_reset}, 32'b10);

`ifdef IMEM_LOADER_CHECKSUM_EN
        base = nw;
        do_start();
        sq = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_load(sq, 0, t0);
        wait_end(td);
        check("cs_bad_flag", 32'(err_checksum), 32'd1);
        check("cs_bad_state", {cpu_reset, done}, 32'b10);
        check("cs_bad_data", wr_data[base], 32'h12345678);
        do_start();
        check("cs_clear", 32'(err_checksum), 32'd0);
        sq = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_load(sq, 0, t0);
        wait_end(td);
        check("cs_good", {done, cpu_reset, err_checksum}, 32'b100);
`else
        check("cs_tied", 32'(err_checksum), 32'd0);
`endif

        // reset in the middle of a payload
        do_start();
        for (int i = 0; i < 4; i++) send_byte(s1[i], 0, t0);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(bus.rx_ready), 32'd0);
        check("mid_rst_we", 32'(imem_write_enabled), 32'd0);
        check("mid_rst_addr", imem_address, 32'd0);
        check("mid_rst_data", imem_data, 32'd0);
        check("mid_rst_flags", {cpu_reset, busy, done, err_overflow,
                                err_checksum}, 32'b10000);
        base = nw;
        do_start();
        send_load(s1, 0, t0);
        wait_end(td);
        check("rl_nw", nw - base, 32'd2);
        check("rl_a0", wr_addr[base], 32'd0);
        check("rl_d0", wr_data[base], 32'h20080005);
        check("rl_d1", wr_data[base+1], 32'h8C090004);
        check("rl_done", {done, cpu_reset}, 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
